// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: load/store opcodes, FSM states
// and the access-width decode used by the arbiter.
package mem_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_READ,
    MC_WRITE,
    MC_DONE
  } mc_state_e;

  // Bytes moved by an opcode; 0 marks an opcode the controller does not know.
  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates load/store and instruction-fetch requests and serializes each
// access onto a byte-wide synchronous RAM/IO bus, one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h0003_0000,
  parameter logic [31:0] IO_MASK = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        clear,
  input  logic        lsb_req,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic [5:0]  lsb_op,
  output logic        lsb_ok,
  output logic [31:0] lsb_rdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ok,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mc_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  k_q, k_d;
  logic [23:0] asm_q, asm_d;
  logic        src_if_q, src_if_d;
  logic        wr_q, wr_d;
  logic [31:0] mem_a_d;
  logic [7:0]  mem_dout_d;
  logic        lsb_ok_d, if_ok_q, if_ok_d;
  logic [31:0] lsb_rdata_d, if_data_d;
  logic [2:0]  lsb_n;
  logic [4:0]  rd_sh, last_sh, wr_sh;
  logic [31:0] result;

  function automatic logic in_io(input logic [31:0] a);
    return (a & IO_MASK) == IO_BASE;
  endfunction

  // In READ, k counts edges since accept; byte k-1 is on mem_din. In WRITE, k
  // is the index of the next byte to issue.
  assign lsb_n   = op_bytes(lsb_op);
  assign rd_sh   = {k_q[1:0] - 2'd1, 3'b000};
  assign last_sh = {n_q[1:0] - 2'd1, 3'b000};
  assign wr_sh   = {k_q[1:0], 3'b000};
  assign result  = {8'h00, asm_q} | (32'(mem_din) << last_sh);

  always_comb begin
    // NOTE: every signal takes its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    n_d         = n_q;
    k_d         = k_q;
    asm_d       = asm_q;
    src_if_d    = src_if_q;
    wr_d        = wr_q;
    mem_a_d     = mem_a;
    mem_dout_d  = mem_dout;
    lsb_ok_d    = lsb_ok;
    lsb_rdata_d = lsb_rdata;
    if_ok_d     = if_ok_q;
    if_data_d   = if_data;

    case (state_q)
      MC_IDLE: begin
        if (lsb_req) begin
          src_if_d = 1'b0;
          addr_d   = lsb_addr;
          wdata_d  = lsb_wdata;
          n_d      = lsb_n;
          k_d      = 3'd0;
          asm_d    = '0;
          if (lsb_n == 3'd0) begin
            state_d     = MC_DONE;
            lsb_ok_d    = 1'b1;
            lsb_rdata_d = '0;
          end else if (op_is_store(lsb_op)) begin
            state_d = MC_WRITE;
            // Byte 0 goes out on the accept edge unless the IO buffer is full.
            if (!(in_io(lsb_addr) && io_buffer_full)) begin
              wr_d       = 1'b1;
              mem_a_d    = lsb_addr;
              mem_dout_d = lsb_wdata[7:0];
              k_d        = 3'd1;
            end
          end else begin
            state_d = MC_READ;
            mem_a_d = lsb_addr;
          end
        end else if (if_req && !clear) begin
          src_if_d = 1'b1;
          addr_d   = if_addr;
          n_d      = 3'd4;
          k_d      = 3'd0;
          asm_d    = '0;
          state_d  = MC_READ;
          mem_a_d  = if_addr;
        end
      end

      MC_READ: begin
        if (src_if_q && clear) begin
          state_d = MC_IDLE;
        end else begin
          k_d = k_q + 3'd1;
          if (k_q + 3'd1 < n_q) mem_a_d = addr_q + 32'(k_q) + 32'd1;
          if (k_q == n_q) begin
            state_d = MC_DONE;
            if (src_if_q) begin
              if_ok_d   = 1'b1;
              if_data_d = result;
            end else begin
              lsb_ok_d    = 1'b1;
              lsb_rdata_d = result;
            end
          end else if (k_q != 3'd0) begin
            asm_d = asm_q | (24'(mem_din) << rd_sh);
          end
        end
      end

      MC_WRITE: begin
        if (k_q == n_q) begin
          wr_d        = 1'b0;
          state_d     = MC_DONE;
          lsb_ok_d    = 1'b1;
          lsb_rdata_d = '0;
        end else if (in_io(addr_q) && io_buffer_full) begin
          wr_d = 1'b0;
        end else begin
          wr_d       = 1'b1;
          mem_a_d    = addr_q + 32'(k_q);
          mem_dout_d = 8'(wdata_q >> wr_sh);
          k_d        = k_q + 3'd1;
        end
      end

      default: begin
        state_d  = MC_IDLE;
        lsb_ok_d = 1'b0;
        if_ok_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MC_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      n_q       <= '0;
      k_q       <= '0;
      asm_q     <= '0;
      src_if_q  <= 1'b0;
      wr_q      <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= '0;
      lsb_ok    <= 1'b0;
      lsb_rdata <= '0;
      if_ok_q   <= 1'b0;
      if_data   <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      n_q       <= n_d;
      k_q       <= k_d;
      asm_q     <= asm_d;
      src_if_q  <= src_if_d;
      wr_q      <= wr_d;
      mem_a     <= mem_a_d;
      mem_dout  <= mem_dout_d;
      lsb_ok    <= lsb_ok_d;
      lsb_rdata <= lsb_rdata_d;
      if_ok_q   <= if_ok_d;
      if_data   <= if_data_d;
    end
  end

  // A mispredict in the DONE cycle of a fetch must suppress its completion.
  assign if_ok  = if_ok_q & ~clear;
  assign mem_wr = wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of load/store vectors with hand-computed
// results, then cycle-exact sequences for arbitration, clear, IO stall, reset, rdy.
`timescale 1ns/1ps
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        lsb_req = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_wdata = '0;
  logic [5:0]  lsb_op = '0;
  logic        lsb_ok;
  logic [31:0] lsb_rdata;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ok;
  logic [31:0] if_data;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_op(lsb_op),
    .lsb_ok(lsb_ok), .lsb_rdata(lsb_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_ok(if_ok), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears the cycle after the address.
  logic [7:0] ram [0:65535] = '{default: 8'h00};
  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (!rst_n) begin
      ram[16'h1000] <= 8'h11; ram[16'h1001] <= 8'h22;
      ram[16'h1002] <= 8'h33; ram[16'h1003] <= 8'h44;
      ram[16'h0010] <= 8'h9C; ram[16'hFFFF] <= 8'h77;
      ram[16'h0000] <= 8'h13; ram[16'h0001] <= 8'h05;
    end else if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic lsb_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output int lat);
    @(negedge clk);
    lsb_req = 1'b1; lsb_op = op; lsb_addr = addr; lsb_wdata = wdata;
    lat = -1; data = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (lsb_ok) begin
        lat = c; data = lsb_rdata;
        break;
      end
    end
    lsb_req = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_data;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] data;
    int lat;

    vecs[0]  = '{"lw_1000",   OP_LW,  32'h0000_1000, 32'h0,          1'b1, 32'h4433_2211, 5};
    vecs[1]  = '{"lb_1001",   OP_LB,  32'h0000_1001, 32'h0,          1'b1, 32'h0000_0022, 2};
    vecs[2]  = '{"lh_1002",   OP_LH,  32'h0000_1002, 32'h0,          1'b1, 32'h0000_4433, 3};
    vecs[3]  = '{"lhu_1000",  OP_LHU, 32'h0000_1000, 32'h0,          1'b1, 32'h0000_2211, 3};
    vecs[4]  = '{"lbu_1003",  OP_LBU, 32'h0000_1003, 32'h0,          1'b1, 32'h0000_0044, 2};
    vecs[5]  = '{"sw_2000",   OP_SW,  32'h0000_2000, 32'hCAFE_F00D,  1'b0, 32'h0,         4};
    vecs[6]  = '{"lw_2000",   OP_LW,  32'h0000_2000, 32'h0,          1'b1, 32'hCAFE_F00D, 5};
    vecs[7]  = '{"sb_2005",   OP_SB,  32'h0000_2005, 32'h0000_005A,  1'b0, 32'h0,         1};
    vecs[8]  = '{"lw_2004",   OP_LW,  32'h0000_2004, 32'h0,          1'b1, 32'h0000_5A00, 5};
    vecs[9]  = '{"bad_op",    6'h3F,  32'h0000_1000, 32'h0,          1'b1, 32'h0,         0};
    vecs[10] = '{"lh_wrap",   OP_LH,  32'hFFFF_FFFF, 32'h0,          1'b1, 32'h0000_1377, 3};

    // Reset state
    #2;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_lsb_ok", 32'(lsb_ok), 32'h0);
    check("rst_lsb_rdata", lsb_rdata, 32'h0);
    check("rst_if_ok", 32'(if_ok), 32'h0);
    check("rst_if_data", if_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven loads and stores
    for (int i = 0; i < 11; i++) begin
      lsb_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, data, lat);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].chk_data) check({vecs[i].name, "_data"}, data, vecs[i].exp_data);
    end

    // LW address sequence and completion cycle
    @(negedge clk);
    lsb_req = 1'b1; lsb_op = OP_LW; lsb_addr = 32'h1000;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 3) check($sformatf("lwseq_mem_a_c%0d", c), mem_a, 32'h1000 + 32'(c));
      check($sformatf("lwseq_wr_c%0d", c), 32'(mem_wr), 32'h0);
      check($sformatf("lwseq_ok_c%0d", c), 32'(lsb_ok), 32'(c == 5));
    end
    check("lwseq_rdata", lsb_rdata, 32'h4433_2211);
    lsb_req = 1'b0;

    // SH byte sequence
    @(negedge clk);
    lsb_req = 1'b1; lsb_op = OP_SH; lsb_addr = 32'h2002; lsb_wdata = 32'h0000_BEEF;
    @(negedge clk);
    check("sh_c0_wr", 32'(mem_wr), 32'h1);
    check("sh_c0_a", mem_a, 32'h2002);
    check("sh_c0_dout", 32'(mem_dout), 32'hEF);
    @(negedge clk);
    check("sh_c1_wr", 32'(mem_wr), 32'h1);
    check("sh_c1_a", mem_a, 32'h2003);
    check("sh_c1_dout", 32'(mem_dout), 32'hBE);
    check("sh_c1_ok", 32'(lsb_ok), 32'h0);
    @(negedge clk);
    check("sh_c2_wr", 32'(mem_wr), 32'h0);
    check("sh_c2_ok", 32'(lsb_ok), 32'h1);
    lsb_req = 1'b0;

    // Simultaneous requests: load/store wins, fetch follows after one idle cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    lsb_req = 1'b1; lsb_op = OP_LBU; lsb_addr = 32'h10;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("arb_lsb_ok_c%0d", c), 32'(lsb_ok), 32'(c == 2));
      check($sformatf("arb_if_ok_c%0d", c), 32'(if_ok), 32'(c == 9));
      if (c == 2) begin
        check("arb_lsb_rdata", lsb_rdata, 32'h0000_009C);
        lsb_req = 1'b0;
      end
      if (c == 9) begin
        check("arb_if_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
      end
    end

    // clear aborts a fetch; a load issued with the clear completes on time
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("clr_if_ok_c%0d", c), 32'(if_ok), 32'h0);
      check($sformatf("clr_lsb_ok_c%0d", c), 32'(lsb_ok), 32'(c == 9));
      if (c == 9) begin
        check("clr_lw_data", lsb_rdata, 32'h4433_2211);
        lsb_req = 1'b0;
      end
      if (c == 2) begin
        clear = 1'b1; if_req = 1'b0;
        lsb_req = 1'b1; lsb_op = OP_LW; lsb_addr = 32'h1000;
      end else begin
        clear = 1'b0;
      end
    end

    // IO write stall
    @(negedge clk);
    lsb_req = 1'b1; lsb_op = OP_SB; lsb_addr = 32'h0003_0000; lsb_wdata = 32'hA5;
    io_buffer_full = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("io_wr_c%0d", c), 32'(mem_wr), 32'(c == 3));
      check($sformatf("io_ok_c%0d", c), 32'(lsb_ok), 32'(c == 4));
      if (c == 3) begin
        check("io_a", mem_a, 32'h0003_0000);
        check("io_dout", 32'(mem_dout), 32'hA5);
      end
      if (c == 2) io_buffer_full = 1'b0;
    end
    lsb_req = 1'b0;

    // Reset in the middle of a LW
    @(negedge clk);
    lsb_req = 1'b1; lsb_op = OP_LW; lsb_addr = 32'h1000;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_a", mem_a, 32'h0);
    check("midrst_lsb_ok", 32'(lsb_ok), 32'h0);
    check("midrst_lsb_rdata", lsb_rdata, 32'h0);
    check("midrst_mem_wr", 32'(mem_wr), 32'h0);
    @(negedge clk);
    lsb_req = 1'b0; rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("postrst_ok_c%0d", c), 32'(lsb_ok), 32'h0);
    end

    // rdy low for two edges in the middle of a SW
    @(negedge clk);
    lsb_req = 1'b1; lsb_op = OP_SW; lsb_addr = 32'h2010; lsb_wdata = 32'h0102_0304;
    @(negedge clk);
    check("rdy_c0_wr", 32'(mem_wr), 32'h1);
    check("rdy_c0_a", mem_a, 32'h2010);
    @(negedge clk);
    rdy = 1'b0;
    #1;
    check("rdy_c1_wr", 32'(mem_wr), 32'h0);
    check("rdy_c1_a", mem_a, 32'h2011);
    @(negedge clk);
    check("rdy_c2_wr", 32'(mem_wr), 32'h0);
    check("rdy_c2_a", mem_a, 32'h2011);
    check("rdy_c2_ok", 32'(lsb_ok), 32'h0);
    @(negedge clk);
    rdy = 1'b1;
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("rdy_ok_c%0d", c), 32'(lsb_ok), 32'(c == 6));
    end
    lsb_req = 1'b0;
    lsb_txn(OP_LW, 32'h2010, 32'h0, data, lat);
    check("rdy_readback_lat", 32'(lat), 32'd5);
    check("rdy_readback_data", data, 32'h0102_0304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller: the responder end of the load/store buffer's memory request interface and of the instruction-fetch request interface. It arbitrates the two clients and serializes each 1/2/4-byte access onto the byte-wide synchronous RAM/IO bus, one byte per cycle. Loads return raw little-endian data; the load/store buffer performs sign extension. It sits between the load/store buffer and instruction fetch on one side and the top-level RAM bus on the other.

## Interface
Parameters:
- IO_BASE, 32'h0003_0000: first address of the IO region.
- IO_MASK, 32'hFFFF_0000: an address is in the IO region when addr & IO_MASK == IO_BASE.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- rdy  in  1  global enable; low freezes all state
- clear  in  1  flush pulse from mispredict; aborts an in-flight fetch
- lsb_req  in  1  load/store buffer request; held until lsb_ok
- lsb_addr  in  32  byte address
- lsb_wdata  in  32  store data, already masked to the access width
- lsb_op  in  6  `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW from defines.v
- lsb_ok  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, valid while lsb_ok is high
- if_req  in  1  fetch request; held until if_ok
- if_addr  in  32  word fetch address
- if_ok  out  1  one-cycle completion pulse
- if_data  out  32  instruction word, valid while if_ok is high
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO write back-pressure

## Operation
- States: IDLE, READ, WRITE, DONE.
- Byte count: 1 for `LB/`LBU/`SB, 2 for `LH/`LHU/`SH, 4 for `LW/`SW and for fetch.
- IDLE, arbitration:
  - lsb_req wins over if_req when both are high.
  - When a request is accepted, latch addr, op and byte count, and clear the byte counter k.
  - A load or fetch goes to READ; a store goes to WRITE.
- Unknown lsb_op with lsb_req high: go straight to DONE. No RAM access, lsb_rdata = 0.
- READ:
  - mem_a = addr+k is registered at accept edge E0, then incremented each edge through addr+N-1. mem_wr = 0.
  - RAM returns the byte for the address presented in cycle c during cycle c+1. Byte k is captured at edge E(k+2).
  - The last byte goes combinationally into the result at E(N+1), which also moves to DONE.
- WRITE:
  - At edge E(k), register mem_wr = 1, mem_a = addr+k and mem_dout = byte k of wdata, for k = 0..N-1.
  - At E(N), register mem_wr = 0 and move to DONE.
- Result assembly: little-endian; byte k lands in bits [8k+7:8k]; unused upper bytes are 0.
- DONE:
  - The matching ok output is high for exactly this cycle, with its data output valid.
  - New requests are ignored in this cycle.
  - Next edge returns to IDLE.
- IO stall: in WRITE, if addr is in the IO region and io_buffer_full is high, register mem_wr = 0 and hold k until io_buffer_full falls.
- clear:
  - During a fetch (READ or DONE for IF): abort, if_ok stays 0, return to IDLE next edge.
  - During an LSB transaction: ignored; the access completes.
  - In IDLE: if_req is not accepted that cycle.
- rdy low: state, counters and outputs hold, except mem_wr, which is forced 0.

## Timing
- Reset values (asynchronous, on rst_n low): state IDLE; mem_a, mem_dout, mem_wr, lsb_ok, lsb_rdata, if_ok, if_data all 0.
- Reset mid-transaction discards the transaction with no partial ok.
- Edges are numbered from the accept edge E0.
- Load of N bytes: ok high during cycle N+1. LW = 5 cycles, LB = 2 cycles.
- Fetch: if_ok high during cycle 5.
- Store of N bytes: ok high during cycle N, plus any IO stall cycles.
- Back-to-back: the earliest next accept is the edge ending the DONE cycle plus one, i.e. one idle cycle between transactions.
- Requesters may drop req combinationally in the ok cycle. The controller never samples req in DONE.
- Address arithmetic is 32-bit and wraps modulo 2^32.

## Structure
- defines.v (shared):
  - lsb_op opcode constants;
  - state encodings MC_IDLE/MC_READ/MC_WRITE/MC_DONE;
  - IO region constants.
- No sub-module. Byte-count decode is a local function; one FSM with a 3-bit counter and a 24-bit assembly register.

## Test plan
- LW at 0x1000, RAM holds 11,22,33,44 → mem_a 0x1000..0x1003 in cycles 0..3; lsb_ok in cycle 5 with lsb_rdata = 0x44332211.
- SH at 0x2002, wdata 0x0000BEEF → mem_wr with 0xEF@0x2002 in cycle 0 and 0xBE@0x2003 in cycle 1; mem_wr = 0 and lsb_ok in cycle 2.
- if_req at 0x0 and LBU at 0x10 (byte 0x9C) in the same cycle → lsb_ok in cycle 2 with 0x0000009C; fetch accepted after DONE, if_ok 5 cycles later.
- clear in cycle 2 of a fetch → no if_ok; IDLE next cycle; a following LW completes normally.
- SB to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for those cycles; write issues the cycle after it falls; lsb_ok the next cycle.
- rst_n low mid-LW, and separately rdy low for 2 cycles mid-SW → reset: all outputs 0 immediately with no lsb_ok; rdy: mem_wr = 0 and mem_a held, then the store resumes and completes.
